// File: rtl/bcd_opg_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : bcd_opg_scheduler
// Description : Shares one serial BCD odd-parity generator between two digit
//               requesters. Arbitrates, clears the generator, shifts the digit
//               in serially, captures the parity bit and returns it with
//               error flags through a response handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_opg_scheduler #(
    parameter int MSB_FIRST   = 1,  // 1: digit[3] shifted first, 0: digit[0] first
    parameter int ROUND_ROBIN = 1   // 1: alternate on contention, 0: req0 always wins
) (
    input  logic       clock,
    input  logic       reset,        // asynchronous, active-low
    input  logic       req0_valid,
    input  logic [3:0] req0_digit,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic [3:0] req1_digit,
    output logic       req1_ready,
    output logic       opg_x,
    output logic       opg_clr_n,
    input  logic       opg_z,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic       rsp_id,
    output logic [3:0] rsp_digit,
    output logic       rsp_parity,
    output logic       rsp_bad_bcd,
    output logic       rsp_mismatch
);

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_clr   = 2'd1;
    localparam logic [1:0] c_st_shift = 2'd2;
    localparam logic [1:0] c_st_resp  = 2'd3;

    localparam logic [1:0] c_last_bit = 2'd3;
    localparam logic [3:0] c_max_bcd  = 4'd9;

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    logic [1:0] r_state;
    logic [1:0] r_bit_cnt;
    logic       r_last_gnt;
    logic       r_id;
    logic [3:0] r_digit;
    logic       r_parity;
    logic       r_bad_bcd;
    logic       r_mismatch;

    // ------------------------------------------------------------------------
    // Combinational signals
    // ------------------------------------------------------------------------
    logic [1:0] w_next_state;
    logic       w_gnt_any;
    logic       w_gnt_id;
    logic [3:0] w_gnt_digit;
    logic       w_gnt_bad;
    logic       w_accept;
    logic [1:0] w_bit_idx;
    logic       w_exp_parity;

    // ------------------------------------------------------------------------
    // Bit order of the serial stream is fixed at elaboration time
    // ------------------------------------------------------------------------
    generate
        if (MSB_FIRST != 0) begin : g_msb_first
            assign w_bit_idx = c_last_bit - r_bit_cnt;
        end else begin : g_lsb_first
            assign w_bit_idx = r_bit_cnt;
        end
    endgenerate

    // Odd-parity bit the generator is expected to produce for the held digit
    assign w_exp_parity = ~^r_digit;

    // Arbitration: a lone requester always wins; on contention either
    // alternate against the previous winner or favour requester 0.
    always_comb begin
        w_gnt_any = req0_valid | req1_valid;
        w_gnt_id  = 1'b0;
        if (req0_valid && req1_valid) begin
            w_gnt_id = (ROUND_ROBIN != 0) ? ~r_last_gnt : 1'b0;
        end else if (req1_valid) begin
            w_gnt_id = 1'b1;
        end
    end

    assign w_gnt_digit = w_gnt_id ? req1_digit : req0_digit;
    assign w_gnt_bad   = (w_gnt_digit > c_max_bcd);

    // A grant is only issued while no job is outstanding
    assign w_accept    = (r_state == c_st_idle) && w_gnt_any;

    // Ready pulses are suppressed while reset is held so nothing is
    // mistaken for an accept during reset.
    assign req0_ready  = reset & w_accept & ~w_gnt_id;
    assign req1_ready  = reset & w_accept &  w_gnt_id;

    // Generator interface: clear pulse spans the single CLR cycle and also
    // follows the scheduler reset; serial data only driven while shifting.
    assign opg_clr_n   = reset & (r_state != c_st_clr);
    assign opg_x       = (r_state == c_st_shift) & r_digit[w_bit_idx];

    // Response outputs come straight from the job registers
    assign rsp_valid    = (r_state == c_st_resp);
    assign rsp_id       = r_id;
    assign rsp_digit    = r_digit;
    assign rsp_parity   = r_parity;
    assign rsp_bad_bcd  = r_bad_bcd;
    assign rsp_mismatch = r_mismatch;

    // State register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic: bad digits skip the generator entirely
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_st_idle: begin
                if (w_accept) begin
                    w_next_state = w_gnt_bad ? c_st_resp : c_st_clr;
                end
            end
            c_st_clr: begin
                w_next_state = c_st_shift;
            end
            c_st_shift: begin
                if (r_bit_cnt == c_last_bit) begin
                    w_next_state = c_st_resp;
                end
            end
            c_st_resp: begin
                if (rsp_ready) begin
                    w_next_state = c_st_idle;
                end
            end
            default: begin
                w_next_state = c_st_idle;
            end
        endcase
    end

    // Job datapath: latch on accept, count bits, capture parity on last bit
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_bit_cnt  <= 2'd0;
            r_last_gnt <= 1'b1;
            r_id       <= 1'b0;
            r_digit    <= 4'd0;
            r_parity   <= 1'b0;
            r_bad_bcd  <= 1'b0;
            r_mismatch <= 1'b0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (w_accept) begin
                        r_id       <= w_gnt_id;
                        r_last_gnt <= w_gnt_id;
                        r_digit    <= w_gnt_digit;
                        r_bad_bcd  <= w_gnt_bad;
                        r_parity   <= 1'b0;
                        r_mismatch <= 1'b0;
                    end
                end
                c_st_clr: begin
                    r_bit_cnt <= 2'd0;
                end
                c_st_shift: begin
                    r_bit_cnt <= r_bit_cnt + 2'd1;
                    if (r_bit_cnt == c_last_bit) begin
                        r_parity   <= opg_z;
                        r_mismatch <= (opg_z != w_exp_parity);
                    end
                end
                default: begin
                    // RESP holds every field stable until the handshake
                end
            endcase
        end
    end

endmodule
`default_nettype wire
